// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared state encoding and sizing helpers for the sort sequencer, control unit and datapath
package sort_pkg;

   localparam int SORT_N      = 8;
   localparam int SORT_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SORT = 3'd2,
      ST_RD   = 3'd3,
      ST_CAP  = 3'd4,
      ST_OUT  = 3'd5
   } seq_state_t;

   // A batch of one word still needs a one-bit address bus.
   function automatic int addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sort_stream_sequencer.sv
// rtl/sort_stream_sequencer.sv - loads a batch into memory, hands it to the sorter, streams the sorted words back out
module sort_stream_sequencer
   import sort_pkg::*;
#(
   parameter int N      = SORT_N,
   parameter int DATA_W = SORT_DATA_W,
   parameter int ADDR_W = addr_w(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_grant,
   output logic              sort_start,
   input  logic              sort_done,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N - 1);

   seq_state_t        state;
   seq_state_t        state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              in_fire;
   logic              out_fire;

   assign in_fire  = (state == ST_LOAD) && in_valid;
   assign out_fire = (state == ST_OUT) && out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = ST_LOAD;
         ST_LOAD: if (in_fire && (wr_ptr == LAST_PTR)) state_nxt = ST_SORT;
         ST_SORT: if (sort_done) state_nxt = ST_RD;
         ST_RD:   state_nxt = ST_CAP;
         ST_CAP:  state_nxt = ST_OUT;
         ST_OUT:  if (out_ready) state_nxt = out_last ? ST_LOAD : ST_RD;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         out_data <= '0;
         out_last <= 1'b0;
      end else begin
         state <= state_nxt;
         if (in_fire) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if ((state == ST_SORT) && sort_done) begin
            rd_ptr <= '0;
         end
         // Holding register: only reloaded in CAP, so it stays put under backpressure.
         if (state == ST_CAP) begin
            out_data <= mem_rdata;
            out_last <= (rd_ptr == LAST_PTR);
         end
         if (out_fire) begin
            rd_ptr <= out_last ? '0 : rd_ptr + 1'b1;
         end
      end
   end

   // All strobes decode straight from state so an async reset drops them at once.
   assign in_ready   = (state == ST_LOAD);
   assign mem_we     = in_fire;
   assign mem_wdata  = in_fire ? in_data : '0;
   assign mem_re     = (state == ST_RD);
   assign mem_addr   = (state == ST_RD)   ? rd_ptr :
                       (state == ST_LOAD) ? wr_ptr : '0;
   assign mem_grant  = (state != ST_SORT);
   assign sort_start = (state == ST_SORT);
   assign out_valid  = (state == ST_OUT);
   assign busy       = (state == ST_SORT) || (state == ST_RD) ||
                       (state == ST_CAP)  || (state == ST_OUT);

endmodule

// File: tb/tb_sort_stream_sequencer.sv
// tb/tb_sort_stream_sequencer.sv - scoreboard bench with behavioural memory and sorter models
module tb_sort_stream_sequencer;
   import sort_pkg::*;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int AW = addr_w(N);

   typedef logic [DW-1:0] word_arr_t [N];

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;
   logic          mem_grant;
   logic          sort_start;
   logic          sort_done;
   logic          busy;

   logic          done_model;
   logic          done_glitch;
   int            sort_delay;
   int            sort_cnt;
   word_arr_t     mem;

   int            n_pass = 0;
   int            n_chk  = 0;
   int            n_re   = 0;
   logic [DW:0]   exp_q [$];

   always #5 clk = ~clk;

   sort_stream_sequencer #(.N(N), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .mem_grant  (mem_grant),
      .sort_start (sort_start),
      .sort_done  (sort_done),
      .busy       (busy)
   );

   function automatic word_arr_t sort_words(input word_arr_t a);
      word_arr_t     r;
      logic [DW-1:0] t;
      r = a;
      for (int i = 0; i < N - 1; i++)
         for (int j = 0; j < N - 1 - i; j++)
            if (r[j] > r[j+1]) begin
               t      = r[j];
               r[j]   = r[j+1];
               r[j+1] = t;
            end
      return r;
   endfunction

   assign sort_done = done_model | done_glitch;

   // Memory with one-cycle read latency plus a sorter that sorts in place after sort_delay cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sort_cnt   <= 0;
         done_model <= 1'b0;
      end else begin
         if (mem_grant && mem_we) mem[mem_addr] <= mem_wdata;
         if (mem_grant && mem_re) mem_rdata <= mem[mem_addr];
         if (sort_start && !mem_grant) begin
            if (!done_model) begin
               if (sort_cnt >= sort_delay - 1) begin
                  mem        <= sort_words(mem);
                  done_model <= 1'b1;
               end else begin
                  sort_cnt <= sort_cnt + 1;
               end
            end
         end else begin
            done_model <= 1'b0;
            sort_cnt   <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic load(input word_arr_t words, input bit gapped, input bit glitch);
      int        acc = 0;
      int        cyc = 0;
      word_arr_t s;
      done_glitch = glitch;
      while (acc < N && cyc < 500) begin
         @(posedge clk); #1;
         in_valid = gapped ? (cyc % 2 == 0) : 1'b1;
         in_data  = words[acc];
         cyc++;
         @(negedge clk);
         chk("ld_no_start", 32'(sort_start), 0);
         if (in_valid && in_ready) begin
            chk("ld_we", 32'(mem_we), 1);
            chk("ld_addr", 32'(mem_addr), acc);
            acc++;
         end else begin
            chk("ld_we_idle", 32'(mem_we), 0);
         end
      end
      done_glitch = 1'b0;
      chk("ld_accepts", acc, N);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("sort_start_up", 32'(sort_start), 1);
      chk("sort_grant_off", 32'(mem_grant), 0);
      chk("sort_in_ready", 32'(in_ready), 0);
      chk("sort_busy", 32'(busy), 1);
      s = sort_words(words);
      for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), s[i]});
   endtask

   task automatic wait_sort();
      int g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!sort_done && g < 1000);
      chk("sort_done_seen", 32'(sort_done), 1);
      chk("sort_start_held", 32'(sort_start), 1);
      chk("sort_no_grant", 32'(mem_grant), 0);
      @(negedge clk);
      chk("start_drop", 32'(sort_start), 0);
      chk("rd_re", 32'(mem_re), 1);
      chk("rd_addr", 32'(mem_addr), 0);
      chk("rd_grant", 32'(mem_grant), 1);
      n_re = mem_re ? 1 : 0;
   endtask

   task automatic drain(input int stall_val, input int stall_cycles, input int max_words,
                        input bit check_lat, output int iters);
      int          got  = 0;
      int          held = 0;
      int          it   = 0;
      logic [DW:0] e;
      while (got < max_words && it < 3000) begin
         @(posedge clk); #1;
         if (out_valid && (out_data == stall_val) && held < stall_cycles) begin
            out_ready = 1'b0;
            held++;
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
         it++;
         if (mem_re) n_re++;
         if (check_lat && it == 1) chk("lat_cap", 32'(out_valid), 0);
         if (check_lat && it == 2) chk("lat_out", 32'(out_valid), 1);
         if (!out_ready) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), stall_val);
            chk("bp_no_re", 32'(mem_re), 0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("out_extra", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("out_word", 32'({out_last, out_data}), 32'(e));
            end
            got++;
         end
      end
      chk("drain_words", got, max_words);
      if (stall_val >= 0) chk("bp_held", held, stall_cycles);
      iters = it;
   endtask

   word_arr_t w1 = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
   word_arr_t w2 = '{8'd4, 8'd8, 8'd3, 8'd6, 8'd1, 8'd7, 8'd5, 8'd2};
   word_arr_t w3 = '{8'd9, 8'd40, 8'd2, 8'd77, 8'd13, 8'd4, 8'd60, 8'd21};
   word_arr_t w4 = '{8'd200, 8'd17, 8'd255, 8'd0, 8'd17, 8'd99, 8'd1, 8'd128};

   initial begin
      int          it;
      int          g;
      logic [DW:0] e;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b1;
      done_glitch = 1'b0;
      sort_delay  = 200;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_in_ready", 32'(in_ready), 0);
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_out_last", 32'(out_last), 0);
         chk("rst_out_data", 32'(out_data), 0);
         chk("rst_mem_we", 32'(mem_we), 0);
         chk("rst_mem_re", 32'(mem_re), 0);
         chk("rst_mem_addr", 32'(mem_addr), 0);
         chk("rst_sort_start", 32'(sort_start), 0);
         chk("rst_mem_grant", 32'(mem_grant), 1);
         chk("rst_busy", 32'(busy), 0);
      end
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("idle_grant", 32'(mem_grant), 1);

      // Batch 1: back-to-back input, long sort, no backpressure.
      load(w1, 1'b0, 1'b0);
      wait_sort();
      drain(-1, 0, N, 1'b1, it);
      chk("thru_cycles", it, 3 * N - 1);
      chk("re_count_1", n_re, N);
      @(negedge clk);
      chk("back_to_load", 32'(in_ready), 1);
      chk("load_not_busy", 32'(busy), 0);

      // Batch 2: gapped input with a stray sort_done, then stall on word 3.
      sort_delay = 5;
      load(w2, 1'b1, 1'b1);
      wait_sort();
      drain(3, 5, N, 1'b0, it);
      chk("re_count_2", n_re, N);

      // Batch 3: aborted by reset while word 4 is presented.
      load(w3, 1'b0, 1'b0);
      wait_sort();
      drain(-1, 0, 3, 1'b0, it);
      g = 0;
      do begin
         @(posedge clk); #1;
         g++;
      end while (!out_valid && g < 10);
      chk("abort_in_out", 32'(out_valid), 1);
      e = exp_q[0];
      chk("abort_word4", 32'(out_data), 32'(e[DW-1:0]));
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_re", 32'(mem_re), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_grant", 32'(mem_grant), 1);
      chk("abort_data", 32'(out_data), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_idle", 32'(in_ready), 0);

      // Batch 4: fresh batch after the abort, with duplicates and extremes.
      load(w4, 1'b0, 1'b0);
      wait_sort();
      drain(-1, 0, N, 1'b1, it);
      chk("re_count_4", n_re, N);
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sort_stream_sequencer.md
Name: sort_stream_sequencer

Overview:
Sits around the bubble-sort control/datapath pair and owns the data memory whenever the sorter is idle.
- Accepts a fixed-length stream of N words on a valid/ready input and writes them to memory addresses 0..N-1.
- Raises start to the sort control unit and holds it until that unit reports done.
- Reads the sorted array back out of memory as a valid/ready output stream, with last marking the final word.
- Top level muxes the memory port between this block and the sorter datapath using mem_grant.

Parameters:
N, 8, number of words per sort batch (N >= 1)
DATA_W, 8, data word width
ADDR_W, $clog2(N) (minimum 1), memory address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  DATA_W  input word
out_valid  out  1  sorted word valid
out_ready  in  1  downstream accepts sorted word
out_data  out  DATA_W  sorted word, ascending order
out_last  out  1  high with the N-th output word
mem_addr  out  ADDR_W  memory address (meaningful only while mem_grant=1)
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable; mem_rdata is valid the cycle after
mem_rdata  in  DATA_W  memory read data
mem_grant  out  1  1 = this block drives the memory port; 0 = the sorter does
sort_start  out  1  start request to the sort control unit
sort_done  in  1  done from the sort control unit
busy  out  1  high in every state except IDLE and LOAD

Behaviour:
- States: IDLE, LOAD, SORT, RD, CAP, OUT. Reset (async, rst_n=0) forces IDLE.
- IDLE -> LOAD unconditionally, after one cycle.
- Reset values:
  - in_ready=0, out_valid=0, out_last=0, out_data=0.
  - mem_we=0, mem_re=0, mem_addr=0, sort_start=0, mem_grant=1, busy=0.
  - wr_ptr=0, rd_ptr=0.
- LOAD:
  - in_ready=1, mem_grant=1.
  - On in_valid & in_ready in the same cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=in_data (combinational).
  - wr_ptr increments on each accept.
  - The accept with wr_ptr==N-1 clears wr_ptr and moves to SORT.
- SORT:
  - sort_start=1, mem_grant=0, in_ready=0; no memory strobes.
  - Held until sort_done=1 is sampled, then -> RD with rd_ptr=0.
  - sort_start drops in RD, which releases the control unit from its done state back to idle.
- RD: mem_re=1, mem_addr=rd_ptr, mem_grant=1. -> CAP.
- CAP: out_data <= mem_rdata, out_last <= (rd_ptr==N-1). -> OUT.
- OUT:
  - out_valid=1; out_data and out_last are stable while out_valid & !out_ready.
  - On out_ready:
    - If out_last: clear rd_ptr and go -> LOAD.
    - Otherwise: rd_ptr+1 and go -> RD.
- Throughput: one output word per 3 cycles with out_ready tied high.
  - First out_valid rises 2 cycles after the cycle in which sort_done is sampled.
- Pointers are ADDR_W bits and never wrap past N-1; they are compared against N-1, not a power of two.
- Input arriving outside LOAD is not accepted (in_ready=0). No data is dropped.
- sort_done seen outside SORT is ignored.
- N=1: a single accept goes to SORT; the sorter returns done immediately; one word is output with out_last=1.
- Reset mid-operation (any state) aborts the batch:
  - Pointers are cleared and all strobes drop immediately (async).
  - Memory contents are undefined for the next batch until it is reloaded.
- busy=1 in SORT, RD, CAP and OUT.

Decomposition:
- Shared package sort_pkg: seq_state_t enum, default N/DATA_W constants, and the ADDR_W derivation function, all reused by the sort control unit and datapath.
- Single module; no sub-module needed. The output holding register is part of this module.

Test Plan:
- Reset release: hold rst_n=0 for 3 cycles then release -> in_ready=0 for one cycle (IDLE), then in_ready=1; mem_grant=1, sort_start=0 throughout.
- Load N=8 words 5,3,8,1,7,2,6,4 back-to-back -> mem_we high 8 cycles at addresses 0..7; sort_start rises the cycle after the 8th accept; mem_grant=0.
- Sorter model asserts sort_done after 200 cycles -> sort_start falls the next cycle; outputs are 1,2,3,4,5,6,7,8 with out_last only on 8; block returns to LOAD with in_ready=1.
- Backpressure: out_ready low for 5 cycles on word 3 -> out_valid stays 1 and out_data stays 3; no extra mem_re strobes occur; the sequence completes intact.
- Gapped input: in_valid toggles every other cycle -> wr_ptr advances only on accepts; SORT is entered only after exactly 8 accepts.
- Abort: assert rst_n=0 during OUT on word 4 -> out_valid=0 and mem_re=0 asynchronously; after release, a fresh batch of 8 loads and outputs sorted correctly.
